draw_rect_render: RTL



---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_timing_delay.sv | 37 +++
 rtl/draw_rect_render.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA stream widths, colour constants and the timing bundle type.
// Used by draw_rect_render and vga_timing_delay.
package vga_pkg;

    localparam int CNT_W   = 11;
    localparam int COLOR_W = 12;
    localparam int POS_W   = 12;

    localparam logic [COLOR_W-1:0] COLOR_BLACK = 12'h000;
    localparam logic [COLOR_W-1:0] COLOR_RED   = 12'hF00;
    localparam logic [COLOR_W-1:0] COLOR_GREEN = 12'h0F0;
    localparam logic [COLOR_W-1:0] COLOR_BLUE  = 12'h00F;
    localparam logic [COLOR_W-1:0] COLOR_WHITE = 12'hFFF;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
    } vga_timing_t;

    // Half-open interval test on unsigned 13-bit values: lo <= val < hi.
    function automatic logic in_span(input logic [12:0] val,
                                     input logic [12:0] lo,
                                     input logic [12:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_timing_delay.sv
// N-stage register chain for the VGA timing bundle, synchronous active-high reset.
// Keeps timing outputs aligned with the colour pipeline by construction.
module vga_timing_delay
    import vga_pkg::*;
#(
    parameter int N = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  vga_timing_t in_timing,
    output vga_timing_t out_timing
);

    vga_timing_t stage_q [N];
    vga_timing_t stage_d [N];

    always_comb begin
        stage_d[0] = in_timing;
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stage_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            stage_q[i] <= stage_d[i];
        end
    end

    assign out_timing = stage_q[N-1];

endmodule

// File: rtl/draw_rect_render.sv
// Overlays a RECT_W x RECT_H rectangle on the VGA pixel stream, 2-cycle latency.
// Define DRAW_RECT_BORDER_EN to draw only a BORDER_W-thick outline instead of a fill.
module draw_rect_render
    import vga_pkg::*;
#(
    parameter int                 RECT_W     = 48,
    parameter int                 RECT_H     = 64,
    parameter logic [COLOR_W-1:0] RECT_COLOR = 12'hF00,
    parameter int                 BORDER_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [POS_W-1:0]   xpos,
    input  logic [POS_W-1:0]   ypos,
    input  logic [CNT_W-1:0]   in_hcount,
    input  logic [CNT_W-1:0]   in_vcount,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic               in_hblnk,
    input  logic               in_vblnk,
    input  logic [COLOR_W-1:0] in_rgb,
    output logic [CNT_W-1:0]   out_hcount,
    output logic [CNT_W-1:0]   out_vcount,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_hblnk,
    output logic               out_vblnk,
    output logic [COLOR_W-1:0] out_rgb
);

`ifdef DRAW_RECT_BORDER_EN
    localparam logic OUTLINE_ONLY = 1'b1;
`else
    localparam logic OUTLINE_ONLY = 1'b0;
`endif

    localparam logic [12:0] W_EXT  = 13'(RECT_W);
    localparam logic [12:0] H_EXT  = 13'(RECT_H);
    localparam logic [12:0] BW_EXT = 13'(BORDER_W);

    logic               vblnk_prev_q, vblnk_prev_d;
    logic [POS_W-1:0]   x_lat_q, x_lat_d;
    logic [POS_W-1:0]   y_lat_q, y_lat_d;
    logic [COLOR_W-1:0] rgb_d1_q, rgb_d1_d;
    logic               hit_q, hit_d;
    logic               blank_q, blank_d;
    logic [COLOR_W-1:0] rgb_q, rgb_d;

    logic [12:0] hc_ext, vc_ext;
    logic [12:0] x_lo, x_hi, y_lo, y_hi;
    logic        hit_x, hit_y, on_edge;

    vga_timing_t in_timing;
    vga_timing_t out_timing;

    // Position is sampled only on the vblank rising edge so a frame never tears.
    always_comb begin
        vblnk_prev_d = in_vblnk;
        x_lat_d      = x_lat_q;
        y_lat_d      = y_lat_q;
        if (in_vblnk && !vblnk_prev_q) begin
            x_lat_d = xpos;
            y_lat_d = ypos;
        end
        if (rst) begin
            vblnk_prev_d = 1'b0;
            x_lat_d      = '0;
            y_lat_d      = '0;
        end
    end

    // 13-bit bounds cannot wrap, so a rectangle past the edge is simply clipped.
    always_comb begin
        hc_ext  = {2'b00, in_hcount};
        vc_ext  = {2'b00, in_vcount};
        x_lo    = {1'b0, x_lat_q};
        y_lo    = {1'b0, y_lat_q};
        x_hi    = x_lo + W_EXT;
        y_hi    = y_lo + H_EXT;
        hit_x   = in_span(hc_ext, x_lo, x_hi);
        hit_y   = in_span(vc_ext, y_lo, y_hi);
        on_edge = (hc_ext <  x_lo + BW_EXT) ||
                  (hc_ext >= x_hi - BW_EXT) ||
                  (vc_ext <  y_lo + BW_EXT) ||
                  (vc_ext >= y_hi - BW_EXT);
    end

    always_comb begin
        rgb_d1_d = in_rgb;
        blank_d  = in_hblnk | in_vblnk;
        hit_d    = hit_x && hit_y && (!OUTLINE_ONLY || on_edge);
        if (rst) begin
            rgb_d1_d = '0;
            blank_d  = 1'b0;
            hit_d    = 1'b0;
        end
    end

    always_comb begin
        if (blank_q) begin
            rgb_d = COLOR_BLACK;
        end else if (hit_q) begin
            rgb_d = RECT_COLOR;
        end else begin
            rgb_d = rgb_d1_q;
        end
        if (rst) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        vblnk_prev_q <= vblnk_prev_d;
        x_lat_q      <= x_lat_d;
        y_lat_q      <= y_lat_d;
        rgb_d1_q     <= rgb_d1_d;
        hit_q        <= hit_d;
        blank_q      <= blank_d;
        rgb_q        <= rgb_d;
    end

    assign in_timing.hcount = in_hcount;
    assign in_timing.vcount = in_vcount;
    assign in_timing.hsync  = in_hsync;
    assign in_timing.vsync  = in_vsync;
    assign in_timing.hblnk  = in_hblnk;
    assign in_timing.vblnk  = in_vblnk;

    vga_timing_delay #(
        .N (2)
    ) u_timing_delay (
        .clk        (clk),
        .rst        (rst),
        .in_timing  (in_timing),
        .out_timing (out_timing)
    );

    assign out_hcount = out_timing.hcount;
    assign out_vcount = out_timing.vcount;
    assign out_hsync  = out_timing.hsync;
    assign out_vsync  = out_timing.vsync;
    assign out_hblnk  = out_timing.hblnk;
    assign out_vblnk  = out_timing.vblnk;
    assign out_rgb    = rgb_q;

endmodule
